// File: rtl/fifo_rd_pkg.sv
// Shared width helpers for the FIFO read-side stream adapter, plus an
// elaboration-time depth check used by the top level.
package fifo_rd_pkg;

    // Width needed to count 0..depth inclusive (occupancy and in-flight counters).
    function automatic int occ_w(input int depth);
        return $clog2(depth + 1);
    endfunction

    // Width of a circular-buffer pointer; never narrower than one bit.
    function automatic int ptr_w(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// The output buffer must cover the full read round trip plus one word so the
// credit loop never starves; LAT itself must be at least one cycle.
`ifndef FIFO_RD_DEPTH_CHECK
`define FIFO_RD_DEPTH_CHECK(od, lat) \
    if (((od) < (lat) + 2) || ((lat) < 1)) begin : g_depth_check \
        $error("fifo_rd_stream: ODEPTH must be >= LAT+2 and LAT >= 1"); \
    end
`endif

// File: rtl/fifo_rd_stream_reg_buf.sv
// Register-based circular buffer holding words returned by the FIFO until the
// stream sink accepts them. Depth need not be a power of two.
module reg_buf
    import fifo_rd_pkg::*;
#(
    parameter int DW     = 18,
    parameter int ODEPTH = 4,
    localparam int OW    = occ_w(ODEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic          pop,
    input  logic [DW-1:0] din,
    output logic [DW-1:0] dout,
    output logic [OW-1:0] occ
);

    localparam int PW = ptr_w(ODEPTH);

    logic [DW-1:0] mem_q [ODEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [OW-1:0] occ_q, occ_d;
    logic          do_push;
    logic          do_pop;

    // Explicit compare-wrap so non power-of-two depths work.
    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(ODEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    // A pop frees a slot in the same cycle, so a push into a full buffer is
    // allowed when it coincides with a pop.
    assign do_pop  = pop && (occ_q != '0);
    assign do_push = push && ((occ_q != OW'(ODEPTH)) || do_pop);

    // Next pointers and occupancy.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        occ_d    = occ_q;
        if (do_push) begin
            wr_ptr_d = ptr_inc(wr_ptr_q);
        end
        if (do_pop) begin
            rd_ptr_d = ptr_inc(rd_ptr_q);
        end
        if (do_push && !do_pop) begin
            occ_d = occ_q + OW'(1);
        end else if (do_pop && !do_push) begin
            occ_d = occ_q - OW'(1);
        end
    end

    // Pointer and occupancy registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            occ_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            occ_q    <= occ_d;
        end
    end

    // Storage flops; cleared on reset so the head reads zero when empty.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < ODEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (do_push) begin
            mem_q[wr_ptr_q] <= din;
        end
    end

    assign dout = mem_q[rd_ptr_q];
    assign occ  = occ_q;

endmodule

// File: rtl/fifo_rd_stream.sv
// Read-side adapter behind the async FIFO: turns the fixed-latency
// ren/dout_valid interface into a first-word-fall-through valid/ready stream.
// Reads are issued against credit (occupancy + reads in flight), so fifo_ren
// depends only on registered state and never on m_ready.
module fifo_rd_stream
    import fifo_rd_pkg::*;
#(
    parameter int DW     = 18,
    parameter int LAT    = 1,
    parameter int ODEPTH = 4,
    localparam int OW    = occ_w(ODEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          fifo_rempty,
    output logic          fifo_ren,
    input  logic [DW-1:0] fifo_dout,
    input  logic          fifo_dout_valid,
    output logic          m_valid,
    input  logic          m_ready,
    output logic [DW-1:0] m_data,
    output logic [OW-1:0] occ,
    output logic          err_ovf,
    output logic          err_spur
);

    `FIFO_RD_DEPTH_CHECK(ODEPTH, LAT)

    logic [OW-1:0] inflight_q, inflight_d;
    logic          err_ovf_q, err_ovf_d;
    logic          err_spur_q, err_spur_d;
    logic [OW:0]   credit_used;
    logic          ret_valid;
    logic          ret_accept;
    logic          ret_spur;
    logic          ret_drop_full;
    logic          buf_push;
    logic          buf_pop;

    // One extra bit so occ + inflight cannot wrap before the compare.
    assign credit_used = {1'b0, occ} + {1'b0, inflight_q};
    assign fifo_ren    = !rst && !fifo_rempty && (credit_used < (OW + 1)'(ODEPTH));

    assign m_valid = (occ != '0);
    assign buf_pop = m_valid && m_ready;

    // Returns are only meaningful when a read is outstanding; anything else
    // is dropped and flagged. A return into a full, non-draining buffer is
    // dropped but still retires its read.
    assign ret_valid     = fifo_dout_valid && !rst;
    assign ret_accept    = ret_valid && (inflight_q != '0);
    assign ret_spur      = ret_valid && (inflight_q == '0);
    assign ret_drop_full = ret_accept && (occ == OW'(ODEPTH)) && !buf_pop;
    assign buf_push      = ret_accept && !ret_drop_full;

    reg_buf #(
        .DW     (DW),
        .ODEPTH (ODEPTH)
    ) u_buf (
        .clk  (clk),
        .rst  (rst),
        .push (buf_push),
        .pop  (buf_pop),
        .din  (fifo_dout),
        .dout (m_data),
        .occ  (occ)
    );

    // Outstanding-read count and sticky error flags, next state.
    always_comb begin
        inflight_d = inflight_q + OW'(fifo_ren) - OW'(ret_accept);
        err_ovf_d  = err_ovf_q || ret_drop_full;
        err_spur_d = err_spur_q || ret_spur;
    end

    // Counter and flag registers; reset discards any reads still in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            inflight_q <= '0;
            err_ovf_q  <= 1'b0;
            err_spur_q <= 1'b0;
        end else begin
            inflight_q <= inflight_d;
            err_ovf_q  <= err_ovf_d;
            err_spur_q <= err_spur_d;
        end
    end

    assign err_ovf  = err_ovf_q;
    assign err_spur = err_spur_q;

endmodule

// File: tb/tb_fifo_rd_stream.sv
// Bench for fifo_rd_stream: a behavioural LAT=1 FIFO feeds the DUT, a
// scoreboard queue holds the words the sink should see, and a monitor pops
// and compares on every accepted beat.
module tb_fifo_rd_stream;

    localparam int DW     = 18;
    localparam int LAT    = 1;
    localparam int ODEPTH = 4;
    localparam int OW     = 3;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          fifo_rempty = 1'b1;
    logic          fifo_dout_valid = 1'b0;
    logic [DW-1:0] fifo_dout = '0;
    logic          m_ready = 1'b0;
    logic          fifo_ren;
    logic          m_valid;
    logic [DW-1:0] m_data;
    logic [OW-1:0] occ;
    logic          err_ovf;
    logic          err_spur;

    always #5 clk = ~clk;

    fifo_rd_stream #(
        .DW     (DW),
        .LAT    (LAT),
        .ODEPTH (ODEPTH)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .fifo_rempty     (fifo_rempty),
        .fifo_ren        (fifo_ren),
        .fifo_dout       (fifo_dout),
        .fifo_dout_valid (fifo_dout_valid),
        .m_valid         (m_valid),
        .m_ready         (m_ready),
        .m_data          (m_data),
        .occ             (occ),
        .err_ovf         (err_ovf),
        .err_spur        (err_spur)
    );

    int            n_cmp = 0;
    int            n_err = 0;
    logic [DW-1:0] fifo_mem [$];
    logic [DW-1:0] exp_q [$];
    int            cyc = 0;
    int            ren_cnt = 0;
    int            ren_while_empty = 0;
    int            first_ren = -1;
    int            last_ren = -1;
    int            first_mv = -1;
    int            beat_cnt = 0;
    int            first_beat = -1;
    int            last_beat = -1;
    bit            inj_pending = 1'b0;
    logic [DW-1:0] inj_data = '0;
    logic          model_ren;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, act, exp, $time);
        end else begin
            $display("ok   %s: 0x%0h (t=%0t)", name, act, $time);
        end
    endtask

    // FIFO model: sample fifo_ren on the edge, return the word one cycle later.
    // An injected return is used only when no real return occupies the cycle.
    always @(posedge clk) begin
        if (fifo_ren) begin
            ren_cnt++;
            if (fifo_rempty) ren_while_empty++;
            if (first_ren < 0) first_ren = cyc;
            last_ren = cyc;
        end
        model_ren = fifo_ren && (fifo_mem.size() > 0);
        cyc++;
        #1;
        if (model_ren) begin
            fifo_dout       = fifo_mem.pop_front();
            fifo_dout_valid = 1'b1;
        end else if (inj_pending) begin
            fifo_dout       = inj_data;
            fifo_dout_valid = 1'b1;
            inj_pending     = 1'b0;
        end else begin
            fifo_dout       = '0;
            fifo_dout_valid = 1'b0;
        end
        fifo_rempty = (fifo_mem.size() == 0);
    end

    // Monitor: every accepted beat is compared against the scoreboard head.
    always @(negedge clk) begin
        if (!rst && m_valid && m_ready) begin
            beat_cnt++;
            if (first_beat < 0) first_beat = cyc;
            last_beat = cyc;
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL beat_unexpected: got 0x%0h, want no beat", m_data);
            end else begin
                check("beat", 32'(m_data), 32'(exp_q.pop_front()));
            end
        end
        if (!rst && m_valid && first_mv < 0) first_mv = cyc;
    end

    task automatic load(input int base, input int n, input bit expect_beats);
        for (int i = 0; i < n; i++) begin
            fifo_mem.push_back(DW'(base + i));
            if (expect_beats) exp_q.push_back(DW'(base + i));
        end
    endtask

    task automatic clr_ren();
        ren_cnt   = 0;
        first_ren = -1;
        last_ren  = -1;
        first_mv  = -1;
    endtask

    task automatic clr_beat();
        beat_cnt   = 0;
        first_beat = -1;
        last_beat  = -1;
    endtask

    task automatic wait_drain(input int budget);
        int k = 0;
        while (exp_q.size() != 0 && k < budget) begin
            @(posedge clk);
            k++;
        end
        check("drain_left", 32'(exp_q.size()), 32'd0);
    endtask

    task automatic step_in();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, want finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int k;

        // 1: reset held 3 cycles with the FIFO already non-empty.
        load(0, 16, 1'b1);
        m_ready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_fifo_ren", 32'(fifo_ren), 32'd0);
        check("rst_m_valid", 32'(m_valid), 32'd0);
        check("rst_occ", 32'(occ), 32'd0);
        check("rst_m_data", 32'(m_data), 32'd0);
        check("rst_err_ovf", 32'(err_ovf), 32'd0);
        check("rst_err_spur", 32'(err_spur), 32'd0);
        clr_ren();
        clr_beat();
        step_in();
        rst = 1'b0;

        // 2: streaming 16 words at 1 word/clk.
        wait_drain(80);
        check("stream_ren_cnt", 32'(ren_cnt), 32'd16);
        check("stream_ren_span", 32'(last_ren - first_ren), 32'd15);
        check("stream_latency", 32'(first_mv - first_ren), 32'(LAT + 1));
        check("stream_beats", 32'(beat_cnt), 32'd16);
        check("stream_beat_span", 32'(last_beat - first_beat), 32'd15);

        // 3: backpressure, 10 words with the sink stalled.
        step_in();
        m_ready = 1'b0;
        clr_ren();
        clr_beat();
        load(0, 10, 1'b1);
        repeat (10) @(posedge clk);
        @(negedge clk);
        check("bp_ren_cnt", 32'(ren_cnt), 32'd4);
        check("bp_occ", 32'(occ), 32'd4);
        check("bp_m_valid", 32'(m_valid), 32'd1);
        check("bp_m_data", 32'(m_data), 32'h0);
        repeat (3) @(negedge clk);
        check("bp_m_data_hold", 32'(m_data), 32'h0);
        check("bp_ren_still", 32'(ren_cnt), 32'd4);
        step_in();
        m_ready = 1'b1;
        wait_drain(40);
        check("bp_beats", 32'(beat_cnt), 32'd10);
        check("bp_beat_span", 32'(last_beat - first_beat), 32'd9);
        check("bp_ren_total", 32'(ren_cnt), 32'd10);

        // 4: single word, then empty.
        step_in();
        clr_ren();
        clr_beat();
        load(18'h155, 1, 1'b1);
        repeat (10) @(posedge clk);
        @(negedge clk);
        check("one_ren_cnt", 32'(ren_cnt), 32'd1);
        check("one_beats", 32'(beat_cnt), 32'd1);
        check("ren_while_empty", 32'(ren_while_empty), 32'd0);
        wait_drain(5);

        // 5a: return with nothing in flight.
        step_in();
        inj_data    = 18'h2AA;
        inj_pending = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("spur_flag", 32'(err_spur), 32'd1);
        check("spur_ovf_clear", 32'(err_ovf), 32'd0);
        check("spur_occ", 32'(occ), 32'd0);
        check("spur_m_valid", 32'(m_valid), 32'd0);

        // 5b: return forced into a full buffer with the sink stalled.
        step_in();
        m_ready = 1'b0;
        clr_ren();
        load(18'h30, 4, 1'b1);
        repeat (10) @(posedge clk);
        @(negedge clk);
        check("ovf_pre_occ", 32'(occ), 32'd4);
        check("ovf_pre_ren", 32'(ren_cnt), 32'd4);
        step_in();
        force dut.inflight_q = 3'd1;
        inj_data    = 18'h3FF;
        inj_pending = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1;
        release dut.inflight_q;
        @(negedge clk);
        check("ovf_flag", 32'(err_ovf), 32'd1);
        check("ovf_occ", 32'(occ), 32'd4);
        check("ovf_m_data", 32'(m_data), 32'h30);
        step_in();
        m_ready = 1'b1;
        wait_drain(20);

        // 6: reset in the middle of a burst with occ=3 and one read in flight.
        step_in();
        rst     = 1'b1;
        m_ready = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst2_err_ovf", 32'(err_ovf), 32'd0);
        check("rst2_err_spur", 32'(err_spur), 32'd0);
        step_in();
        rst = 1'b0;
        load(18'h40, 4, 1'b0);
        k = 0;
        @(negedge clk);
        while (occ != 3'd3 && k < 20) begin
            @(negedge clk);
            k++;
        end
        check("mid_occ_reached", 32'(occ), 32'd3);
        rst = 1'b1;
        @(negedge clk);
        check("mid_occ", 32'(occ), 32'd0);
        check("mid_m_valid", 32'(m_valid), 32'd0);
        check("mid_fifo_ren", 32'(fifo_ren), 32'd0);
        step_in();
        rst         = 1'b0;
        inj_data    = 18'h001;
        inj_pending = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("late_spur", 32'(err_spur), 32'd1);
        check("late_occ", 32'(occ), 32'd0);
        check("late_ovf", 32'(err_ovf), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
